// File: rtl/gf2_mult_serial_if.sv
// Operand/result handshake bundle for the digit-serial GF(2) multiplier.
// The master side is the producer/consumer; the slave side is the multiplier.
interface gf2_mult_serial_if #(
    parameter int unsigned WIDTH = 285
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   acc;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     d;

    modport master (
        output in_valid, a, b, acc, out_ready,
        input  in_ready, out_valid, d
    );

    modport slave (
        input  in_valid, a, b, acc, out_ready,
        output in_ready, out_valid, d
    );
endinterface

// File: rtl/gf2_mult_serial.sv
// Digit-serial carry-less (GF(2)[x]) multiplier: DIGIT bits of b per cycle,
// unreduced 2*WIDTH-bit product, optional XOR-accumulate onto the previous result.
module gf2_mult_serial #(
    parameter int unsigned WIDTH = 285,
    parameter int unsigned DIGIT = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    gf2_mult_serial_if.slave  bus
);
    localparam int unsigned N  = (WIDTH + DIGIT - 1) / DIGIT;
    localparam int unsigned PW = N * DIGIT;
    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [DW-1:0]   a_sh_q, a_sh_d;
    logic [PW-1:0]   b_q, b_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [DW-1:0]   partial;

    // a is kept pre-shifted to the current digit position and b is shifted down,
    // so the low DIGIT bits of b_q are always the digit being processed.
    always_comb begin
        partial = '0;
        for (int unsigned j = 0; j < DIGIT; j++) begin
            if (b_q[j]) begin
                partial = partial ^ (a_sh_q << j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_sh_q  <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_sh_q  <= a_sh_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_sh_d  = a_sh_q;
        b_d     = b_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d  = DW'(bus.a);
                    b_d     = PW'(bus.b);
                    k_d     = '0;
                    state_d = RUN;
                    if (!bus.acc) begin
                        acc_d = '0;
                    end
                end
            end
            RUN: begin
                acc_d  = acc_q ^ partial;
                a_sh_d = a_sh_q << DIGIT;
                b_d    = b_q >> DIGIT;
                if (k_q == KW'(N - 1)) begin
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.d         = acc_q;

endmodule

// File: tb/tb_gf2_mult_serial.sv
// Self-checking bench: three instances (8/3, 285/32, 8/8) against a bitwise
// schoolbook carry-less multiply with accumulate tracking.
module tb_gf2_mult_serial;
    localparam int MAXW = 285;
    localparam int MAXD = 2 * MAXW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              vld   [3];
    logic              acc_v [3];
    logic              ordy  [3];
    logic [MAXW-1:0]   av    [3];
    logic [MAXW-1:0]   bv    [3];
    logic              in_rdy[3];
    logic              out_vld[3];
    logic [MAXD-1:0]   dout  [3];

    gf2_mult_serial_if #(.WIDTH(8))   i0 ();
    gf2_mult_serial_if #(.WIDTH(285)) i1 ();
    gf2_mult_serial_if #(.WIDTH(8))   i2 ();

    gf2_mult_serial #(.WIDTH(8),   .DIGIT(3))  u0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
    gf2_mult_serial #(.WIDTH(285), .DIGIT(32)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
    gf2_mult_serial #(.WIDTH(8),   .DIGIT(8))  u2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));

    assign i0.in_valid = vld[0];  assign i0.acc = acc_v[0];  assign i0.out_ready = ordy[0];
    assign i0.a = av[0][7:0];     assign i0.b = bv[0][7:0];
    assign i1.in_valid = vld[1];  assign i1.acc = acc_v[1];  assign i1.out_ready = ordy[1];
    assign i1.a = av[1];          assign i1.b = bv[1];
    assign i2.in_valid = vld[2];  assign i2.acc = acc_v[2];  assign i2.out_ready = ordy[2];
    assign i2.a = av[2][7:0];     assign i2.b = bv[2][7:0];

    assign in_rdy[0] = i0.in_ready;  assign out_vld[0] = i0.out_valid;  assign dout[0] = MAXD'(i0.d);
    assign in_rdy[1] = i1.in_ready;  assign out_vld[1] = i1.out_valid;  assign dout[1] = MAXD'(i1.d);
    assign in_rdy[2] = i2.in_ready;  assign out_vld[2] = i2.out_valid;  assign dout[2] = MAXD'(i2.d);

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int              sel;
        logic [MAXW-1:0] a;
        logic [MAXW-1:0] b;
        logic            acc;
        logic [MAXD-1:0] exp_d;
    } vec_t;

    // Reference: schoolbook carry-less product over every bit of y
    function automatic logic [MAXD-1:0] clmul(input logic [MAXW-1:0] x, input logic [MAXW-1:0] y);
        logic [MAXD-1:0] r;
        r = '0;
        for (int i = 0; i < MAXW; i++) begin
            if (y[i]) r = r ^ (MAXD'(x) << i);
        end
        return r;
    endfunction

    function automatic int n_of(input int sel);
        return (sel == 0) ? 3 : (sel == 1) ? 9 : 1;
    endfunction

    function automatic logic [MAXW-1:0] rand_op(input int sel);
        logic [MAXW-1:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r = (r << 32) | MAXW'($urandom);
        if (sel != 1) r = r & MAXW'(8'hFF);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [MAXD-1:0] act, input logic [MAXD-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One complete operation on instance sel; returns result and accept-to-valid edge count
    task automatic do_op(input int sel, input logic [MAXW-1:0] a, input logic [MAXW-1:0] b,
                         input logic acc, output logic [MAXD-1:0] d, output int lat);
        int w;
        av[sel] = a; bv[sel] = b; acc_v[sel] = acc; vld[sel] = 1'b1; ordy[sel] = 1'b0;
        w = 0;
        while (!in_rdy[sel] && w < 200) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        vld[sel] = 1'b0;
        lat = 0;
        while (!out_vld[sel] && lat < 200) begin @(posedge clk); #1; lat++; end
        d = dout[sel];
        ordy[sel] = 1'b1;
        @(posedge clk); #1;
        ordy[sel] = 1'b0;
        chk("consume_drops_valid", MAXD'(out_vld[sel]), '0);
    endtask

    initial begin
        vec_t            vecs[$];
        logic [MAXD-1:0] d, prev, held;
        logic [MAXW-1:0] x, y, x2, y2;
        logic            ac;
        int              lat, cyc, last, w;
        logic [MAXD-1:0] q[$];

        vecs.push_back('{0, MAXW'(8'h03), MAXW'(8'h03), 1'b0, MAXD'(16'h0005)});
        vecs.push_back('{0, MAXW'(8'hFF), MAXW'(8'hFF), 1'b0, MAXD'(16'h5555)});
        vecs.push_back('{0, MAXW'(8'h03), MAXW'(8'h03), 1'b1, MAXD'(16'h5550)});
        vecs.push_back('{1, MAXW'(1) << 284, MAXW'(1) << 284, 1'b0, MAXD'(1) << 568});
        vecs.push_back('{2, MAXW'(8'h03), MAXW'(8'h07), 1'b0, MAXD'(16'h0009)});
        vecs.push_back('{2, MAXW'(8'hFF), MAXW'(8'h01), 1'b1, MAXD'(16'h00F6)});
        vecs.push_back('{2, MAXW'(8'h80), MAXW'(8'h80), 1'b0, MAXD'(16'h4000)});

        for (int s = 0; s < 3; s++) begin
            vld[s] = 1'b0; acc_v[s] = 1'b0; ordy[s] = 1'b0; av[s] = '0; bv[s] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            chk("reset_in_ready", MAXD'(in_rdy[s]), MAXD'(1));
            chk("reset_out_valid", MAXD'(out_vld[s]), '0);
            chk("reset_d", dout[s], '0);
        end

        // Directed table
        for (int i = 0; i < vecs.size(); i++) begin
            do_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].acc, d, lat);
            chk("table_d", d, vecs[i].exp_d);
            chk("table_latency", MAXD'(lat), MAXD'(n_of(vecs[i].sel)));
        end

        // Random ops with accumulate on the small and the full-size instance
        for (int s = 0; s < 2; s++) begin
            prev = '0;
            for (int i = 0; i < ((s == 0) ? 200 : 1000); i++) begin
                x = rand_op(s); y = rand_op(s);
                if (i % 50 == 1) x = (s == 1) ? '1 : MAXW'(8'hFF);
                if (i % 50 == 2) y = '0;
                ac = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
                do_op(s, x, y, ac, d, lat);
                prev = (ac ? prev : '0) ^ clmul(x, y);
                chk("random_d", d, prev);
                chk("random_latency", MAXD'(lat), MAXD'(n_of(s)));
            end
        end

        // Backpressure: result held, next op queued but not accepted until release
        x = rand_op(1); y = rand_op(1); x2 = rand_op(1); y2 = rand_op(1);
        av[1] = x; bv[1] = y; acc_v[1] = 1'b0; vld[1] = 1'b1; ordy[1] = 1'b0;
        @(posedge clk); #1;
        av[1] = x2; bv[1] = y2;
        w = 0;
        while (!out_vld[1] && w < 200) begin @(posedge clk); #1; w++; end
        chk("bp_latency", MAXD'(w), MAXD'(9));
        held = dout[1];
        chk("bp_first_d", held, clmul(x, y));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_valid_hold", MAXD'(out_vld[1]), MAXD'(1));
            chk("bp_d_hold", dout[1], held);
            chk("bp_in_ready_low", MAXD'(in_rdy[1]), '0);
        end
        ordy[1] = 1'b1;
        @(posedge clk); #1;
        ordy[1] = 1'b0;
        chk("bp_release_valid", MAXD'(out_vld[1]), '0);
        chk("bp_release_in_ready", MAXD'(in_rdy[1]), MAXD'(1));
        @(posedge clk); #1;
        vld[1] = 1'b0;
        chk("bp_next_accepted", MAXD'(in_rdy[1]), '0);
        w = 0;
        while (!out_vld[1] && w < 200) begin @(posedge clk); #1; w++; end
        chk("bp_second_d", dout[1], clmul(x2, y2));
        ordy[1] = 1'b1;
        @(posedge clk); #1;
        ordy[1] = 1'b0;

        // Reset while the digit counter is at 4
        av[1] = rand_op(1) | MAXW'(1); bv[1] = rand_op(1) | MAXW'(1); acc_v[1] = 1'b0; vld[1] = 1'b1;
        @(posedge clk); #1;
        vld[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrun_in_ready", MAXD'(in_rdy[1]), MAXD'(1));
        chk("midrun_out_valid", MAXD'(out_vld[1]), '0);
        chk("midrun_d", dout[1], '0);
        do_op(1, MAXW'(1), MAXW'(1), 1'b1, d, lat);
        chk("after_reset_acc_d", d, MAXD'(1));

        // Back-to-back with in_valid and out_ready held high on the 8/3 instance
        x = rand_op(0); y = rand_op(0);
        av[0] = x; bv[0] = y; acc_v[0] = 1'b0; vld[0] = 1'b1; ordy[0] = 1'b1;
        cyc = 0; last = -1;
        for (int c = 0; c < 60; c++) begin
            automatic logic accepting = in_rdy[0];
            if (accepting) begin
                q.push_back(clmul(x, y));
                if (last >= 0) chk("b2b_spacing", MAXD'(cyc - last), MAXD'(5));
                last = cyc;
            end
            if (out_vld[0]) begin
                if (q.size() == 0) chk("b2b_unexpected_result", MAXD'(1), '0);
                else chk("b2b_d", dout[0], q.pop_front());
            end
            @(posedge clk); #1;
            cyc++;
            if (accepting) begin
                x = rand_op(0); y = rand_op(0);
                av[0] = x; bv[0] = y;
            end
        end
        vld[0] = 1'b0; ordy[0] = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
